// File: rtl/rejection_sample_ctrl_if.sv
// Bundle of control, checker and output-stream signals for rejection_sample_ctrl.
//   slave  : the sampler itself (drives cand_o, FIFO head and status)
//   master : the host / checker side (drives start, abort, seed, N, chk_ok_i, out_ready)
// Signals:
//   start, abort, seed[31:0], num_samples[15:0]  run control
//   cand_o[VEC_W-1:0], chk_ok_i                  candidate to checker, verdict back
//   out_valid, out_ready, out_data[VEC_W-1:0]    accepted-sample stream
//   busy, done, timeout, tries[15:0], accepted[15:0]  status
interface rejection_sample_ctrl_if #(
    parameter int VEC_W = 512
) ();
    logic             start;
    logic             abort;
    logic [31:0]      seed;
    logic [15:0]      num_samples;
    logic [VEC_W-1:0] cand_o;
    logic             chk_ok_i;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [15:0]      tries;
    logic [15:0]      accepted;

    modport slave (
        input  start, abort, seed, num_samples, chk_ok_i, out_ready,
        output cand_o, out_valid, out_data, busy, done, timeout, tries, accepted
    );

    modport master (
        output start, abort, seed, num_samples, chk_ok_i, out_ready,
        input  cand_o, out_valid, out_data, busy, done, timeout, tries, accepted
    );
endinterface

// File: rtl/rejection_sample_ctrl.sv
// Rejection sampler front end: builds pseudo-random candidates from a 32-bit
// Galois LFSR, presents them to an external combinational constraint checker
// and queues accepted candidates in a small FIFO until N are accepted or the
// try budget is spent.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    rejection_sample_ctrl_if.slave (control, checker path, output stream, status)
//
// state   | meaning
// IDLE    | waiting for start
// FILL    | shifting one LFSR word per cycle into the candidate
// CHECK   | candidate stable, checker verdict sampled (stalls if FIFO full)
// DONE    | one-cycle done pulse, back to IDLE
module rejection_sample_ctrl #(
    parameter int          VEC_W      = 512,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_TRIES  = 65535,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input logic                   clk,
    input logic                   rst_n,
    rejection_sample_ctrl_if.slave bus
);
    localparam int WORDS = (VEC_W + 31) / 32;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      MAX_T     = 16'(MAX_TRIES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_lfsr;
    logic [VEC_W-1:0] r_cand;
    logic [WC_W-1:0]  r_wcnt;
    logic [15:0]      r_n;
    logic [15:0]      r_tries;
    logic [15:0]      r_acc;
    logic             r_done;
    logic             r_timeout;

    logic [VEC_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_lfsr_nxt;
    logic [VEC_W-1:0] w_cand_nxt;
    logic             w_full;
    logic             w_in_check;
    logic             w_push;
    logic             w_pop;
    logic             w_eval;
    logic [15:0]      w_tries_inc;
    logic [15:0]      w_acc_nxt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    assign w_lfsr_nxt = lfsr_step(r_lfsr);

    generate
        if (VEC_W <= 32) begin : g_narrow
            assign w_cand_nxt = w_lfsr_nxt[VEC_W-1:0];
        end else begin : g_wide
            assign w_cand_nxt = {r_cand[VEC_W-33:0], w_lfsr_nxt};
        end
    endgenerate

    // Abort wins over a verdict in the same cycle: nothing is pushed or counted.
    assign w_full      = (r_count == FULL_CNT);
    assign w_in_check  = (r_state == S_CHECK) && !bus.abort;
    assign w_push      = w_in_check && bus.chk_ok_i && !w_full;
    assign w_eval      = w_in_check && (!bus.chk_ok_i || !w_full);
    assign w_pop       = (r_count != '0) && bus.out_ready;
    assign w_tries_inc = r_tries + 16'd1;
    assign w_acc_nxt   = w_push ? (r_acc + 16'd1) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lfsr    <= SEED;
            r_cand    <= '0;
            r_wcnt    <= '0;
            r_n       <= '0;
            r_tries   <= '0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lfsr    <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
                        r_n       <= bus.num_samples;
                        r_tries   <= '0;
                        r_acc     <= '0;
                        r_timeout <= 1'b0;
                        r_wcnt    <= '0;
                        if (bus.num_samples == 16'h0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lfsr <= w_lfsr_nxt;
                        r_cand <= w_cand_nxt;
                        if (r_wcnt == LAST_WORD) begin
                            r_wcnt  <= '0;
                            r_state <= S_CHECK;
                        end else begin
                            r_wcnt <= r_wcnt + WC_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_eval) begin
                        r_tries <= w_tries_inc;
                        r_acc   <= w_acc_nxt;
                        if (w_acc_nxt == r_n) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_tries_inc == MAX_T) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_cand;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.cand_o    = r_cand;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.timeout   = r_timeout;
    assign bus.tries     = r_tries;
    assign bus.accepted  = r_acc;
endmodule

// File: tb/tb_rejection_sample_ctrl.sv
// Bench for rejection_sample_ctrl: two instances (generous and tiny try budget)
// sharing one stimulus set; a candidate-level reference model predicts the
// accepted stream and final counters for every run.
module tb_rejection_sample_ctrl;
    localparam int VW     = 64;
    localparam int WORDS  = 2;
    localparam int DEPTH  = 4;
    localparam int MAXT_A = 40;
    localparam int MAXT_B = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic        start;
    logic        abort;
    logic [31:0] seed;
    logic [15:0] num;
    logic        out_ready;
    logic [1:0]  chk_mode;
    logic [7:0]  thr;

    rejection_sample_ctrl_if #(.VEC_W(VW)) ifa ();
    rejection_sample_ctrl_if #(.VEC_W(VW)) ifb ();

    rejection_sample_ctrl #(.VEC_W(VW), .FIFO_DEPTH(DEPTH), .MAX_TRIES(MAXT_A), .SEED(32'h1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rejection_sample_ctrl #(.VEC_W(VW), .FIFO_DEPTH(DEPTH), .MAX_TRIES(MAXT_B), .SEED(32'h1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifa.start       = start & ~sel;
    assign ifb.start       = start & sel;
    assign ifa.abort       = abort & ~sel;
    assign ifb.abort       = abort & sel;
    assign ifa.seed        = seed;
    assign ifb.seed        = seed;
    assign ifa.num_samples = num;
    assign ifb.num_samples = num;
    assign ifa.out_ready   = out_ready;
    assign ifb.out_ready   = out_ready;
    // Stand-in checker: constant verdict, or a threshold on the low candidate byte.
    assign ifa.chk_ok_i = (chk_mode == 2'd2) ? (ifa.cand_o[7:0] < thr) : chk_mode[0];
    assign ifb.chk_ok_i = (chk_mode == 2'd2) ? (ifb.cand_o[7:0] < thr) : chk_mode[0];

    logic [VW-1:0] m_cand, m_data;
    logic          m_valid, m_busy, m_done, m_timeout;
    logic [15:0]   m_tries, m_acc;
    assign m_cand    = sel ? ifb.cand_o    : ifa.cand_o;
    assign m_data    = sel ? ifb.out_data  : ifa.out_data;
    assign m_valid   = sel ? ifb.out_valid : ifa.out_valid;
    assign m_busy    = sel ? ifb.busy      : ifa.busy;
    assign m_done    = sel ? ifb.done      : ifa.done;
    assign m_timeout = sel ? ifb.timeout   : ifa.timeout;
    assign m_tries   = sel ? ifb.tries     : ifa.tries;
    assign m_acc     = sel ? ifb.accepted  : ifa.accepted;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: whole-run outcome from the LFSR rule and verdict rule.
    logic [63:0] exp_q[$];
    int          exp_tries;
    int          exp_acc;
    logic        exp_to;
    logic [63:0] exp_first;

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic model_run(input logic [31:0] sd, input int n, input int maxt,
                             input logic [1:0] mode, input logic [7:0] th);
        logic [31:0] s;
        logic [63:0] c;
        logic        ok;
        s = (sd == 32'h0) ? 32'h1 : sd;
        exp_tries = 0;
        exp_acc   = 0;
        exp_to    = 1'b0;
        exp_first = '0;
        if (n == 0) return;
        while (1) begin
            c = '0;
            for (int w = 0; w < WORDS; w++) begin
                s = ref_step(s);
                c = {c[31:0], s};
            end
            if (exp_tries == 0) exp_first = c;
            ok = (mode == 2'd2) ? (c[7:0] < th) : mode[0];
            exp_tries++;
            if (ok) begin
                exp_q.push_back(c);
                exp_acc++;
            end
            if (exp_acc == n) break;
            if (exp_tries == maxt) begin
                exp_to = 1'b1;
                break;
            end
        end
    endtask

    // Output-stream monitor: every pop must match the model's next sample and
    // a stalled head must already be that sample.
    int done_cnt = 0;
    always @(negedge clk) begin
        if (m_done) done_cnt++;
        if (m_valid && !out_ready && exp_q.size() > 0)
            check_val("hold_data", m_data, exp_q[0]);
        if (m_valid && out_ready) begin
            check_val("pop_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check_val("pop_data", m_data, exp_q.pop_front());
        end
    end

    task automatic drain(input string tag);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        check_val({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        check_val({tag, "_valid_low"}, 64'(m_valid), 64'd0);
    endtask

    task automatic run_case(input logic s_sel, input logic [31:0] sd, input int n,
                            input logic [1:0] mode, input logic [7:0] th,
                            input bit rdy_always, input string tag,
                            output logic [63:0] first_c);
        int cyc;
        int d0;
        bit seen_done;
        bit seen_valid;
        seen_done  = 0;
        seen_valid = 0;
        first_c    = '0;
        sel        = s_sel;
        chk_mode   = mode;
        thr        = th;
        model_run(sd, n, s_sel ? MAXT_B : MAXT_A, mode, th);
        d0   = done_cnt;
        seed = sd;
        num  = 16'(n);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check_val({tag, "_timeout_clr"}, 64'(m_timeout), 64'(n == 0 ? 0 : 0));
        while (cyc < 3000) begin
            if (m_valid) seen_valid = 1;
            if (cyc == WORDS + 1) first_c = m_cand;
            if (m_done) begin
                seen_done = 1;
                break;
            end
            out_ready = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, "_done_seen"}, 64'(seen_done), 64'd1);
        if (rdy_always)
            check_val({tag, "_latency"}, 64'(cyc), 64'(exp_tries * (WORDS + 1) + 1));
        check_val({tag, "_tries"}, 64'(m_tries), 64'(exp_tries));
        check_val({tag, "_accepted"}, 64'(m_acc), 64'(exp_acc));
        check_val({tag, "_timeout"}, 64'(m_timeout), 64'(exp_to));
        check_val({tag, "_busy_at_done"}, 64'(m_busy), 64'(n != 0));
        check_val({tag, "_valid_seen"}, 64'(seen_valid), 64'(exp_acc > 0));
        if (n != 0) check_val({tag, "_first_cand"}, first_c, exp_first);
        drain(tag);
        check_val({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check_val({tag, "_idle_after"}, 64'(m_busy), 64'd0);
        check_val({tag, "_timeout_sticky"}, 64'(m_timeout), 64'(exp_to));
    endtask

    initial begin
        logic [63:0] fc;
        logic [31:0] sd;
        int d0;
        int k;
        rst_n = 1'b0;
        sel = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; num = '0;
        out_ready = 1'b0; chk_mode = 2'd0; thr = '0;
        #2;
        check_val("rst_busy", 64'(m_busy), 64'd0);
        check_val("rst_cand", m_cand, 64'd0);
        check_val("rst_valid", 64'(m_valid), 64'd0);
        check_val("rst_data", m_data, 64'd0);
        check_val("rst_tries", 64'(m_tries), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Always accept, seed 1.
        run_case(1'b0, 32'h1, 3, 2'd1, 8'd0, 1'b1, "accept", fc);
        check_val("accept_first_const", fc, 64'h8020_0003_C030_0002);

        // Always reject on the 5-try instance.
        run_case(1'b1, $urandom, 2, 2'd0, 8'd0, 1'b1, "reject", fc);

        // Seed zero behaves as seed 1; N zero finishes immediately.
        run_case(1'b0, 32'h0, 1, 2'd1, 8'd0, 1'b1, "seed0", fc);
        check_val("seed0_first_word", fc[63:32], 64'h8020_0003);
        run_case(1'b0, $urandom, 0, 2'd1, 8'd0, 1'b1, "nzero", fc);

        // Back-pressure: FIFO fills, FSM stalls, then drains in order.
        sel = 1'b0; chk_mode = 2'd1; sd = $urandom;
        model_run(sd, 6, MAXT_A, 2'd1, 8'd0);
        d0 = done_cnt;
        seed = sd; num = 16'd6; out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check_val("bp_tries_stall", 64'(m_tries), 64'd4);
        check_val("bp_acc_stall", 64'(m_acc), 64'd4);
        check_val("bp_busy_stall", 64'(m_busy), 64'd1);
        check_val("bp_valid_stall", 64'(m_valid), 64'd1);
        out_ready = 1'b1;
        k = 0;
        while (!m_done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("bp_done_seen", 64'(m_done), 64'd1);
        check_val("bp_tries", 64'(m_tries), 64'(exp_tries));
        check_val("bp_acc", 64'(m_acc), 64'd6);
        check_val("bp_timeout", 64'(m_timeout), 64'd0);
        drain("bp");
        check_val("bp_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Abort mid-FILL keeps FIFO and counters, no done pulse.
        sel = 1'b0; chk_mode = 2'd1; sd = $urandom;
        model_run(sd, 2, MAXT_A, 2'd1, 8'd0);
        d0 = done_cnt;
        seed = sd; num = 16'd10; out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (m_acc != 16'd2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("abort_reached_acc2", 64'(m_acc), 64'd2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_val("abort_idle", 64'(m_busy), 64'd0);
        check_val("abort_tries", 64'(m_tries), 64'd2);
        check_val("abort_fifo_kept", 64'(m_valid), 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("abort_still_idle", 64'(m_busy), 64'd0);
        drain("abort");

        // Asynchronous reset in the middle of a CHECK cycle.
        sel = 1'b0; chk_mode = 2'd1;
        seed = $urandom; num = 16'd5; out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check_val("rst_mid_pre_tries", 64'(m_tries), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_busy", 64'(m_busy), 64'd0);
        check_val("rst_mid_cand", m_cand, 64'd0);
        check_val("rst_mid_valid", 64'(m_valid), 64'd0);
        check_val("rst_mid_data", m_data, 64'd0);
        check_val("rst_mid_tries", 64'(m_tries), 64'd0);
        check_val("rst_mid_acc", 64'(m_acc), 64'd0);
        check_val("rst_mid_done", 64'(m_done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(1'b0, $urandom, 3, 2'd1, 8'd0, 1'b1, "post_rst", fc);

        // Randomized runs with a threshold checker and random back-pressure.
        for (int i = 0; i < 12; i++) begin
            run_case(1'((i % 4) == 3), $urandom, $urandom_range(1, 6), 2'd2,
                     8'($urandom_range(24, 200)), 1'($urandom_range(0, 1)), "rand", fc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
